// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master drives requests; the slave (the arithmetic unit) returns results.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  ready, busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output ready, busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop,
// one operand bit per clock, LSB first, under a start/done handshake.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;

    logic             s;
    logic             c_nxt;
    logic             last;

    assign s     = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_nxt = (a_sr[0] & b_sr[0]) |
                   (a_sr[0] & carry)   |
                   (b_sr[0] & carry);
    assign last  = (cnt == CW'(WIDTH - 1));

    assign bus.ready    = (state != RUN);
    assign bus.busy     = (state == RUN);
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

    // Sequencer and serial datapath: load on accept, one bit per RUN edge.
    // On the last bit the carry flop still holds the carry into the MSB,
    // so overflow is that carry XOR the carry leaving the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub | bus.cin;
                        res_sr <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= c_nxt;
                    res_sr <= {s, res_sr[WIDTH-1:1]};
                    cnt    <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        sum_q  <= {s, res_sr[WIDTH-1:1]};
                        cout_q <= c_nxt;
                        ovf_q  <= carry ^ c_nxt;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: a cycle-level behavioural model
// per instance (WIDTH=8 and WIDTH=2) compared against the DUT every cycle.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    serial_addsub_if #(.WIDTH(8)) i8 ();
    serial_addsub_if #(.WIDTH(2)) i2 ();

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i8.slave)
    );

    serial_addsub #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i2.slave)
    );

    initial forever #5 clk = ~clk;

    // Reference arithmetic: returns {overflow, cout, sum[63:0]}.
    function automatic logic [65:0] ref_op(int w, logic sub,
                                           longint unsigned a,
                                           longint unsigned b,
                                           logic cin);
        longint unsigned mask, bo, full, s;
        logic co, ov;
        mask = (64'd1 << w) - 64'd1;
        bo   = sub ? (~b & mask) : (b & mask);
        full = (a & mask) + bo + (sub ? 64'd1 : 64'(cin));
        s    = full & mask;
        co   = full[w];
        ov   = (a[w-1] == bo[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    task automatic chk(string name, longint unsigned act,
                       longint unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state per instance: edge count, accept edge, pending/last result.
    longint      e_cnt[2];
    longint      n0[2];
    logic [65:0] pend[2];
    logic [65:0] res[2];

    // One model step per clock; the inputs passed in are the ones the
    // preceding rising edge sampled.
    task automatic step(int k, int w, logic rstv, logic start, logic sub,
                        longint unsigned a, longint unsigned b, logic cin,
                        logic ready, logic busy, logic done, logic cout,
                        logic ovf, longint unsigned sum);
        logic busy_prev, xb, xd;
        logic [68:0] exp_v, act_v;
        if (!rstv) begin
            e_cnt[k] = 0;
            n0[k]    = -100;
            res[k]   = '0;
            pend[k]  = '0;
        end else begin
            e_cnt[k]++;
            if (e_cnt[k] == n0[k] + w) res[k] = pend[k];
            busy_prev = (e_cnt[k] - 1 >= n0[k]) &&
                        (e_cnt[k] - 1 <= n0[k] + w - 1);
            if (!busy_prev && start) begin
                n0[k]   = e_cnt[k];
                pend[k] = ref_op(w, sub, a, b, cin);
            end
        end
        xb = rstv && (e_cnt[k] >= n0[k]) && (e_cnt[k] <= n0[k] + w - 1);
        xd = rstv && (e_cnt[k] == n0[k] + w);
        exp_v = {~xb, xb, xd, res[k][64], res[k][65], res[k][63:0]};
        act_v = {ready, busy, done, cout, ovf, sum};
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL cycle_w%0d e%0d: got %0h expected %0h",
                     w, e_cnt[k], act_v, exp_v);
        end
    endtask

    initial forever begin
        @(negedge clk);
        step(0, 8, rst_n, i8.start, i8.sub, 64'(i8.a), 64'(i8.b), i8.cin,
             i8.ready, i8.busy, i8.done, i8.cout, i8.overflow, 64'(i8.sum));
    end

    initial forever begin
        @(negedge clk);
        step(1, 2, rst_n, i2.start, i2.sub, 64'(i2.a), 64'(i2.b), i2.cin,
             i2.ready, i2.busy, i2.done, i2.cout, i2.overflow, 64'(i2.sum));
    end

    task automatic go8(logic sub, logic [7:0] a, logic [7:0] b, logic cin);
        @(negedge clk);
        #1;
        i8.start = 1'b1;
        i8.sub   = sub;
        i8.a     = a;
        i8.b     = b;
        i8.cin   = cin;
        @(negedge clk);
        #1;
        i8.start = 1'b0;
        i8.sub   = 1'($urandom);
        i8.a     = 8'($urandom);
        i8.b     = 8'($urandom);
        i8.cin   = 1'($urandom);
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i8.done && n < 20);
        if (n >= 20) chk("done8_timeout", 64'(n), 64'd0);
    endtask

    task automatic go2(logic sub, logic [1:0] a, logic [1:0] b, logic cin);
        @(negedge clk);
        #1;
        i2.start = 1'b1;
        i2.sub   = sub;
        i2.a     = a;
        i2.b     = b;
        i2.cin   = cin;
        @(negedge clk);
        #1;
        i2.start = 1'b0;
    endtask

    task automatic wait_done2(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i2.done && n < 20);
        if (n >= 20) chk("done2_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [65:0] r;
        i8.start = 0; i8.sub = 0; i8.a = 0; i8.b = 0; i8.cin = 0;
        i2.start = 0; i2.sub = 0; i2.a = 0; i2.b = 0; i2.cin = 0;

        // Pin the reference model with hand-computed results.
        chk("ref_5a_3c", 64'(ref_op(8, 0, 'h5A, 'h3C, 1)), 64'h3_0097 & 64'hFFFF);
        r = ref_op(8, 0, 'h5A, 'h3C, 1);
        chk("ref_add_flags", {r[65], r[64], r[7:0]}, 64'h297);
        r = ref_op(8, 0, 'hFF, 'h01, 0);
        chk("ref_ff_01", {r[65], r[64], r[7:0]}, 64'h100);
        r = ref_op(8, 1, 'h10, 'h20, 0);
        chk("ref_10_m_20", {r[65], r[64], r[7:0]}, 64'h0F0);
        r = ref_op(8, 1, 'h80, 'h01, 1);
        chk("ref_80_m_01", {r[65], r[64], r[7:0]}, 64'h37F);

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_ready", 64'(i8.ready), 64'd1);
        chk("rst_busy", 64'(i8.busy), 64'd0);
        chk("rst_vals", {i8.done, i8.cout, i8.overflow, i8.sum}, 64'd0);

        // Add 0x5A + 0x3C + 1.
        go8(0, 8'h5A, 8'h3C, 1);
        wait_done8(n);
        chk("t2_latency", 64'(n), 64'd8);
        chk("t2_result", {i8.overflow, i8.cout, i8.sum}, 64'h297);

        // 0xFF + 0x01, then 0x10 - 0x20.
        go8(0, 8'hFF, 8'h01, 0);
        wait_done8(n);
        chk("t3_add", {i8.overflow, i8.cout, i8.sum}, 64'h100);
        go8(1, 8'h10, 8'h20, 0);
        wait_done8(n);
        chk("t3_sub", {i8.overflow, i8.cout, i8.sum}, 64'h0F0);

        // 0x80 - 0x01 with cin set (ignored in subtract mode).
        go8(1, 8'h80, 8'h01, 1);
        wait_done8(n);
        chk("t4_sub", {i8.overflow, i8.cout, i8.sum}, 64'h37F);

        // Start during RUN is ignored; start in DONE runs back-to-back.
        go8(0, 8'h33, 8'h44, 0);
        repeat (2) @(negedge clk);
        #1;
        i8.start = 1'b1;
        i8.a     = 8'hAA;
        i8.b     = 8'hAA;
        @(negedge clk);
        #1;
        i8.start = 1'b0;
        wait_done8(n);
        chk("t5_ignored", {i8.overflow, i8.cout, i8.sum}, 64'h077);
        #1;
        i8.start = 1'b1;
        i8.sub   = 1'b1;
        i8.a     = 8'h05;
        i8.b     = 8'h07;
        i8.cin   = 1'b0;
        @(negedge clk);
        #1;
        i8.start = 1'b0;
        chk("t5_b2b_busy", 64'(i8.busy), 64'd1);
        wait_done8(n);
        chk("t5_b2b_latency", 64'(n), 64'd8);
        chk("t5_b2b_result", {i8.overflow, i8.cout, i8.sum}, 64'h0FE);

        // Random traffic: random starts and operand noise every cycle.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            i8.start = ($urandom % 3) == 0;
            i8.sub   = 1'($urandom);
            i8.a     = 8'($urandom);
            i8.b     = 8'($urandom);
            i8.cin   = 1'($urandom);
        end
        // Start held high continuously.
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            #1;
            i8.start = 1'b1;
            i8.sub   = 1'($urandom);
            i8.a     = 8'($urandom);
            i8.b     = 8'($urandom);
            i8.cin   = 1'($urandom);
        end
        @(negedge clk);
        #1;
        i8.start = 1'b0;
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        go8(1, 8'h80, 8'h01, 1);
        wait_done8(n);
        go8(0, 8'h12, 8'h34, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        chk("t6_busy_pre", 64'(i8.busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_ready", 64'(i8.ready), 64'd1);
        chk("t6_busy", 64'(i8.busy), 64'd0);
        chk("t6_vals", {i8.done, i8.cout, i8.overflow, i8.sum}, 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        go8(0, 8'h01, 8'h01, 0);
        wait_done8(n);
        chk("t6_after", {i8.overflow, i8.cout, i8.sum}, 64'h002);

        // WIDTH=2: every a, b, cin and mode.
        for (int m = 0; m < 16 * 4; m++) begin
            go2(m[5], m[1:0], m[3:2], m[4]);
            wait_done2(n);
            r = ref_op(2, m[5], 64'(m[1:0]), 64'(m[3:2]), m[4]);
            chk($sformatf("w2_op%0d", m),
                {i2.overflow, i2.cout, i2.sum},
                {r[65], r[64], r[1:0]});
        end
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
